// File: rtl/axi_decerr_responder.sv
// AXI4 default slave: absorbs unmapped transactions and answers with an error.
// Write and read sides are independent, one outstanding txn each.
module axi_decerr_responder #(
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter logic [1:0]  RespCode  = 2'b11,
  parameter logic [63:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [31:0]          err_count_o
);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DRAIN,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rstate_e;

  wstate_e     wstate;
  rstate_e     rstate;
  logic [7:0]  rlen;
  logic [7:0]  rcnt;
  logic        aw_hs;
  logic        ar_hs;
  logic [32:0] cnt_sum;

  assign aw_hs    = aw_valid_i & aw_ready_o;
  assign ar_hs    = ar_valid_i & ar_ready_o;
  assign b_resp_o = RespCode;
  assign r_resp_o = RespCode;
  assign r_data_o = RespData[DataWidth-1:0];

  always_comb begin
    cnt_sum = {1'b0, err_count_o}
            + {32'd0, aw_hs}
            + {32'd0, ar_hs};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstate     <= W_IDLE;
      aw_ready_o <= 1'b1;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      b_id_o     <= '0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            b_id_o     <= aw_id_i;
            aw_ready_o <= 1'b0;
            w_ready_o  <= 1'b1;
            wstate     <= W_DRAIN;
          end
        end
        W_DRAIN: begin
          if (w_valid_i && w_last_i) begin
            w_ready_o <= 1'b0;
            b_valid_o <= 1'b1;
            wstate    <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            b_valid_o  <= 1'b0;
            aw_ready_o <= 1'b1;
            wstate     <= W_IDLE;
          end
        end
        default: begin
          aw_ready_o <= 1'b1;
          w_ready_o  <= 1'b0;
          b_valid_o  <= 1'b0;
          wstate     <= W_IDLE;
        end
      endcase
    end
  end

  // r_last is precomputed so it rises with the final beat, not after it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rstate     <= R_IDLE;
      ar_ready_o <= 1'b1;
      r_valid_o  <= 1'b0;
      r_last_o   <= 1'b0;
      r_id_o     <= '0;
      rlen       <= '0;
      rcnt       <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            r_id_o     <= ar_id_i;
            rlen       <= ar_len_i;
            rcnt       <= '0;
            r_last_o   <= (ar_len_i == 8'd0);
            r_valid_o  <= 1'b1;
            ar_ready_o <= 1'b0;
            rstate     <= R_SEND;
          end
        end
        R_SEND: begin
          if (r_ready_i) begin
            if (r_last_o) begin
              r_valid_o  <= 1'b0;
              r_last_o   <= 1'b0;
              ar_ready_o <= 1'b1;
              rstate     <= R_IDLE;
            end else begin
              rcnt     <= rcnt + 8'd1;
              r_last_o <= ((rcnt + 8'd1) == rlen);
            end
          end
        end
        default: begin
          ar_ready_o <= 1'b1;
          r_valid_o  <= 1'b0;
          r_last_o   <= 1'b0;
          rstate     <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_addr_o  <= '0;
      err_count_o <= '0;
    end else begin
      if (aw_hs) begin
        err_addr_o <= aw_addr_i;
      end else if (ar_hs) begin
        err_addr_o <= ar_addr_i;
      end
      if (cnt_sum[32]) begin
        err_count_o <= '1;
      end else begin
        err_count_o <= cnt_sum[31:0];
      end
    end
  end

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Self-checking bench for axi_decerr_responder.
// Directed vector tables, corner sequences and a randomized model run.
module tb_axi_decerr_responder;

  localparam logic [63:0] RDATA = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [1:0]  RESP  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        aw_valid_i, aw_ready_o;
  logic [5:0]  aw_id_i;
  logic [63:0] aw_addr_i;
  logic        w_valid_i, w_ready_o, w_last_i;
  logic        b_valid_o, b_ready_i;
  logic [5:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i, ar_ready_o;
  logic [5:0]  ar_id_i;
  logic [63:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic        r_valid_o, r_ready_i;
  logic [5:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [63:0] err_addr_o;
  logic [31:0] err_count_o;

  axi_decerr_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .err_addr_o(err_addr_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;
  logic [63:0] exp_addr;

  typedef struct {
    logic [5:0]  id;
    logic [7:0]  len;
    logic [63:0] addr;
    bit          tog;
    int          exp_beats;
  } rd_vec_t;

  typedef struct {
    logic [5:0]  id;
    logic [63:0] addr;
    int          nb;
    int          exp_acc;
  } wr_vec_t;

  rd_vec_t rv[5];
  wr_vec_t wv[3];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cnt_add(input int n);
    longint t;
    t = longint'(exp_cnt) + longint'(n);
    exp_cnt = (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(t);
  endtask

  task automatic clear_inputs();
    aw_valid_i = 0; aw_id_i = '0; aw_addr_i = '0;
    w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = '0; ar_addr_i = '0;
    ar_len_i = '0; r_ready_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1;
    step();
    step();
    rst_i = 0;
    exp_cnt = '0;
    exp_addr = '0;
    step();
  endtask

  task automatic do_write(input logic [5:0] id,
                          input logic [63:0] addr,
                          input int nb,
                          output int acc);
    int n;
    int sent;
    bit done;
    bit hs;
    aw_id_i = id; aw_addr_i = addr; aw_valid_i = 1;
    n = 0;
    while (!aw_ready_o && n < 50) begin step(); n++; end
    if (!aw_ready_o) tmo("aw_wait");
    step();
    aw_valid_i = 0;
    cnt_add(1);
    exp_addr = addr;
    chk("aw_ready_in_drain", aw_ready_o, 0);
    chk("w_ready_after_aw", w_ready_o, 1);
    acc = 0; sent = 0; done = 0; n = 0;
    while (!done && n < 100) begin
      w_valid_i = 1;
      w_last_i = (sent == nb - 1);
      hs = w_ready_o;
      step();
      n++;
      if (hs) begin
        acc++;
        sent++;
        if (w_last_i) done = 1;
      end
    end
    w_valid_i = 0; w_last_i = 0;
    if (!done) tmo("w_drain");
    chk("w_ready_after_last", w_ready_o, 0);
    chk("b_valid", b_valid_o, 1);
    chk("b_id", b_id_o, id);
    chk("b_resp", b_resp_o, RESP);
    chk("wr_err_addr", err_addr_o, exp_addr);
    chk("wr_err_count", err_count_o, exp_cnt);
    step();
    chk("b_valid_held", b_valid_o, 1);
    chk("b_id_held", b_id_o, id);
    b_ready_i = 1;
    step();
    b_ready_i = 0;
    chk("b_valid_clear", b_valid_o, 0);
    chk("aw_ready_back", aw_ready_o, 1);
  endtask

  task automatic do_read(input logic [5:0] id,
                         input logic [7:0] len,
                         input logic [63:0] addr,
                         input bit tog,
                         output int beats);
    int n;
    int k;
    bit done;
    bit hs;
    bit lst;
    ar_id_i = id; ar_len_i = len; ar_addr_i = addr;
    ar_valid_i = 1;
    n = 0;
    while (!ar_ready_o && n < 50) begin step(); n++; end
    if (!ar_ready_o) tmo("ar_wait");
    step();
    ar_valid_i = 0;
    cnt_add(1);
    exp_addr = addr;
    chk("ar_ready_in_send", ar_ready_o, 0);
    beats = 0; k = 0; done = 0;
    while (!done && k < 2 * int'(len) + 20) begin
      chk("r_valid", r_valid_o, 1);
      chk("r_id", r_id_o, id);
      chk("r_data", r_data_o, RDATA);
      chk("r_resp", r_resp_o, RESP);
      chk("r_last", r_last_o, beats == int'(len));
      r_ready_i = tog ? (k % 2 == 0) : 1'b1;
      hs = r_ready_i && r_valid_o;
      lst = r_last_o;
      step();
      k++;
      if (hs) begin
        beats++;
        if (lst) done = 1;
      end
    end
    r_ready_i = 0;
    if (!done) tmo("r_burst");
    chk("r_valid_clear", r_valid_o, 0);
    chk("r_last_clear", r_last_o, 0);
    chk("ar_ready_back", ar_ready_o, 1);
    chk("rd_err_addr", err_addr_o, exp_addr);
    chk("rd_err_count", err_count_o, exp_cnt);
  endtask

  task automatic sim_pair(input logic [5:0] awid,
                          input logic [63:0] awaddr,
                          input logic [5:0] arid,
                          input logic [63:0] araddr);
    chk("pair_aw_ready", aw_ready_o, 1);
    chk("pair_ar_ready", ar_ready_o, 1);
    aw_valid_i = 1; aw_id_i = awid; aw_addr_i = awaddr;
    ar_valid_i = 1; ar_id_i = arid; ar_addr_i = araddr;
    ar_len_i = 8'd0;
    step();
    aw_valid_i = 0; ar_valid_i = 0;
    cnt_add(2);
    exp_addr = awaddr;
    chk("pair_err_addr", err_addr_o, exp_addr);
    chk("pair_err_count", err_count_o, exp_cnt);
    chk("pair_w_ready", w_ready_o, 1);
    chk("pair_r_valid", r_valid_o, 1);
    chk("pair_r_last", r_last_o, 1);
    chk("pair_r_id", r_id_o, arid);
    w_valid_i = 1; w_last_i = 1; r_ready_i = 1;
    step();
    w_valid_i = 0; w_last_i = 0; r_ready_i = 0;
    chk("pair_r_done", r_valid_o, 0);
    chk("pair_ar_back", ar_ready_o, 1);
    chk("pair_b_valid", b_valid_o, 1);
    chk("pair_b_id", b_id_o, awid);
    chk("pair_w_done", w_ready_o, 0);
    b_ready_i = 1;
    step();
    b_ready_i = 0;
    chk("pair_b_clear", b_valid_o, 0);
    chk("pair_aw_back", aw_ready_o, 1);
  endtask

  logic [5:0]  t_id, tr_id, wid_m, rid_m;
  logic [63:0] t_addr, tr_addr;
  logic [7:0]  tr_len;
  int          t_nb, t_wleft, wleft, rbeat, rlen_m;
  bit          t_aw_done, tr_ar_done, wpend, rpend;
  bit          aw_h, w_h, b_h, ar_h, r_h;
  int          res;

  task automatic new_wtx();
    t_id = 6'($urandom);
    t_addr = {32'($urandom), 32'($urandom)};
    t_nb = $urandom_range(1, 4);
    t_wleft = t_nb;
    t_aw_done = 0;
    aw_id_i = t_id;
    aw_addr_i = t_addr;
  endtask

  task automatic new_rtx();
    tr_id = 6'($urandom);
    tr_addr = {32'($urandom), 32'($urandom)};
    tr_len = 8'($urandom_range(0, 9));
    tr_ar_done = 0;
    ar_id_i = tr_id;
    ar_addr_i = tr_addr;
    ar_len_i = tr_len;
  endtask

  initial begin
    rv[0] = '{6'h05, 8'd3,   64'h8000_1000, 1'b1, 4};
    rv[1] = '{6'h3F, 8'd0,   64'h0000_0040, 1'b0, 1};
    rv[2] = '{6'h12, 8'd7,   64'h1234_5678, 1'b1, 8};
    rv[3] = '{6'h00, 8'd255, 64'hFFFF_0000, 1'b0, 256};
    rv[4] = '{6'h21, 8'd1,   64'h0A00_0000, 1'b1, 2};
    wv[0] = '{6'h2A, 64'h5000_0000, 4, 4};
    wv[1] = '{6'h01, 64'h0000_0008, 1, 1};
    wv[2] = '{6'h3C, 64'hC000_0000, 7, 7};

    clear_inputs();
    rst_i = 1;
    step();
    step();
    chk("rst_aw_ready", aw_ready_o, 1);
    chk("rst_ar_ready", ar_ready_o, 1);
    chk("rst_w_ready", w_ready_o, 0);
    chk("rst_b_valid", b_valid_o, 0);
    chk("rst_r_valid", r_valid_o, 0);
    chk("rst_r_last", r_last_o, 0);
    chk("rst_b_id", b_id_o, 0);
    chk("rst_r_id", r_id_o, 0);
    chk("rst_err_addr", err_addr_o, 0);
    chk("rst_err_count", err_count_o, 0);
    rst_i = 0;
    exp_cnt = '0;
    exp_addr = '0;
    step();

    ar_valid_i = 1; ar_id_i = 6'h03; ar_len_i = 8'd7;
    ar_addr_i = 64'h4000_0000;
    step();
    ar_valid_i = 0;
    r_ready_i = 1;
    step();
    step();
    chk("pre_rst_r_valid", r_valid_o, 1);
    chk("pre_rst_count", err_count_o, 1);
    rst_i = 1;
    #1;
    chk("mid_rst_r_valid", r_valid_o, 0);
    chk("mid_rst_ar_ready", ar_ready_o, 1);
    chk("mid_rst_count", err_count_o, 0);
    chk("mid_rst_addr", err_addr_o, 0);
    r_ready_i = 0;
    step();
    rst_i = 0;
    exp_cnt = '0;
    exp_addr = '0;
    step();

    foreach (wv[i]) begin
      do_write(wv[i].id, wv[i].addr, wv[i].nb, res);
      chk("wr_vec_accepted", res, wv[i].exp_acc);
    end
    foreach (rv[i]) begin
      do_read(rv[i].id, rv[i].len, rv[i].addr, rv[i].tog, res);
      chk("rd_vec_beats", res, rv[i].exp_beats);
    end

    sim_pair(6'h0F, 64'h6000_0000, 6'h30, 64'h7000_0000);

    w_valid_i = 1; w_last_i = 1;
    for (int i = 0; i < 3; i++) begin
      chk("early_w_stalled", w_ready_o, 0);
      step();
    end
    chk("early_aw_ready", aw_ready_o, 1);
    aw_valid_i = 1; aw_id_i = 6'h11; aw_addr_i = 64'h9000_0000;
    chk("early_w_hs_cycle", w_ready_o, 0);
    step();
    aw_valid_i = 0;
    cnt_add(1);
    exp_addr = 64'h9000_0000;
    chk("early_w_ready", w_ready_o, 1);
    step();
    w_valid_i = 0; w_last_i = 0;
    chk("early_b_valid", b_valid_o, 1);
    chk("early_b_id", b_id_o, 6'h11);
    b_ready_i = 1;
    step();
    b_ready_i = 0;
    chk("early_aw_back", aw_ready_o, 1);
    chk("early_count", err_count_o, exp_cnt);

    force dut.err_count_o = 32'hFFFF_FFFE;
    #1;
    release dut.err_count_o;
    exp_cnt = 32'hFFFF_FFFE;
    chk("sat_preload", err_count_o, exp_cnt);
    sim_pair(6'h22, 64'hA000_0000, 6'h23, 64'hB000_0000);
    chk("sat_max", err_count_o, 32'hFFFF_FFFF);
    sim_pair(6'h24, 64'hA000_0100, 6'h25, 64'hB000_0100);
    chk("sat_hold", err_count_o, 32'hFFFF_FFFF);

    do_reset();
    wpend = 0; wleft = 0; rpend = 0; rbeat = 0; rlen_m = 0;
    wid_m = '0; rid_m = '0;
    new_wtx();
    new_rtx();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_aw_ready", aw_ready_o, !wpend);
      chk("rnd_w_ready", w_ready_o, wpend && wleft > 0);
      chk("rnd_b_valid", b_valid_o, wpend && wleft == 0);
      if (wpend && wleft == 0) begin
        chk("rnd_b_id", b_id_o, wid_m);
        chk("rnd_b_resp", b_resp_o, RESP);
      end
      chk("rnd_ar_ready", ar_ready_o, !rpend);
      chk("rnd_r_valid", r_valid_o, rpend);
      if (rpend) begin
        chk("rnd_r_id", r_id_o, rid_m);
        chk("rnd_r_data", r_data_o, RDATA);
        chk("rnd_r_resp", r_resp_o, RESP);
        chk("rnd_r_last", r_last_o, rbeat == rlen_m);
      end
      chk("rnd_err_count", err_count_o, exp_cnt);
      chk("rnd_err_addr", err_addr_o, exp_addr);

      if (!aw_valid_i && !t_aw_done)
        aw_valid_i = ($urandom_range(0, 2) == 0);
      if (!w_valid_i && t_wleft > 0) begin
        w_valid_i = 1'($urandom_range(0, 1));
        w_last_i = (t_wleft == 1);
      end
      b_ready_i = 1'($urandom_range(0, 1));
      if (!ar_valid_i && !tr_ar_done)
        ar_valid_i = ($urandom_range(0, 2) == 0);
      r_ready_i = 1'($urandom_range(0, 1));

      aw_h = aw_valid_i && aw_ready_o;
      w_h  = w_valid_i && w_ready_o;
      b_h  = b_valid_o && b_ready_i;
      ar_h = ar_valid_i && ar_ready_o;
      r_h  = r_valid_o && r_ready_i;
      step();

      cnt_add(int'(aw_h) + int'(ar_h));
      if (aw_h) exp_addr = t_addr;
      else if (ar_h) exp_addr = tr_addr;
      if (aw_h) begin
        aw_valid_i = 0; t_aw_done = 1;
        wpend = 1; wleft = t_nb; wid_m = t_id;
      end
      if (w_h) begin
        w_valid_i = 0; w_last_i = 0;
        t_wleft--; wleft--;
      end
      if (b_h) begin
        wpend = 0;
        new_wtx();
      end
      if (ar_h) begin
        ar_valid_i = 0; tr_ar_done = 1;
        rpend = 1; rbeat = 0;
        rlen_m = int'(tr_len); rid_m = tr_id;
      end
      if (r_h) begin
        if (rbeat == rlen_m) begin
          rpend = 0;
          new_rtx();
        end else begin
          rbeat++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
